// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter that sits beside the data memory on the
//   core's write path. Writes that land in its 8-byte window are captured into
//   a small TX FIFO and shifted out LSB first on owTx. A combinational status
//   word is offered to the top-level read mux whenever the read address hits
//   the window.
//
//   Register window (address bits [1:0] ignored):
//     +0 TXDATA  write: push iwWriteData[7:0] when iwWstrb[0]=1; reads as 0
//     +4 STATUS  read : {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}
//                write: any nonzero strobe clears overflow
//
//   Ports
//     iwClk        system clock
//     iwRst        asynchronous active-high reset
//     iwWriteAddr  core write address
//     iwWriteData  core write data
//     iwWstrb      byte strobes, nonzero means a write this cycle
//     iwReadAddr   core read address
//     owReadData   status word (combinational from iwReadAddr)
//     owReadHit    read address falls inside the window
//     owTx         serial line, idles high
//     owBusy       frame in flight or bytes still queued
module mmio_uart_tx #(
    parameter logic [31:0] pBaseAddr  = 32'h0001_0000,
    parameter int unsigned pClkPerBit = 32'd5,
    parameter int unsigned pFifoAw    = 3
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    input  logic [31:0] iwReadAddr,
    output logic [31:0] owReadData,
    output logic        owReadHit,
    output logic        owTx,
    output logic        owBusy
);

    localparam int unsigned      Depth      = 2 ** pFifoAw;
    localparam logic [31:0]      BaudReload = pClkPerBit - 32'd1;
    localparam logic [pFifoAw:0] FullCnt    = {1'b1, {pFifoAw{1'b0}}};
    localparam logic [pFifoAw:0] CntOne     = 1;
    localparam logic [pFifoAw-1:0] PtrOne   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FSM / serializer state
    state_t       r_state;
    state_t       w_state_nx;
    logic [31:0]  r_baud;
    logic [31:0]  w_baud_nx;
    logic [2:0]   r_bit;
    logic [2:0]   w_bit_nx;
    logic [7:0]   r_shift;
    logic [7:0]   w_shift_nx;
    logic         r_tx;
    logic         w_tx_nx;

    // FIFO state
    logic [7:0]         r_mem [Depth];
    logic [pFifoAw-1:0] r_wr_ptr;
    logic [pFifoAw-1:0] r_rd_ptr;
    logic [pFifoAw:0]   r_count;
    logic               r_ovf;

    logic        w_wr_hit;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_stat_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_baud_zero;
    logic        w_busy;
    logic [7:0]  w_count8;
    logic [31:0] w_status;
    logic        w_rd_hit;
    logic        w_unused;

    // Bits of the bus that the window decode deliberately ignores.
    assign w_unused = ^{iwWriteData[31:8], iwWriteAddr[1:0], iwReadAddr[1:0]};

    // Write decode
    assign w_wr_hit   = (iwWriteAddr[31:3] == pBaseAddr[31:3]);
    assign w_push_req = w_wr_hit && !iwWriteAddr[2] && iwWstrb[0];
    assign w_stat_wr  = w_wr_hit && iwWriteAddr[2] && (iwWstrb != 4'b0000);

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even when the serializer pops in the same cycle.
    assign w_full  = (r_count == FullCnt);
    assign w_empty = (r_count == '0);
    assign w_push  = w_push_req && !w_full;

    assign w_baud_zero = (r_baud == 32'd0);
    assign w_busy      = (r_state != S_IDLE) || !w_empty;

    // Read path: purely combinational, no clock latency.
    assign w_count8   = 8'(r_count);
    assign w_status   = {16'b0, w_count8, 4'b0, r_ovf, w_busy, w_empty, w_full};
    assign w_rd_hit   = (iwReadAddr[31:3] == pBaseAddr[31:3]);
    assign owReadHit  = w_rd_hit;
    assign owReadData = (w_rd_hit && iwReadAddr[2]) ? w_status : 32'b0;

    assign owTx   = r_tx;
    assign owBusy = w_busy;

    // Next-state logic. owTx is computed one cycle ahead so the line comes
    // straight from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rd_ptr];
                    w_baud_nx  = BaudReload;
                    w_state_nx = S_START;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_zero) begin
                    w_baud_nx  = BaudReload;
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_DATA;
                    w_tx_nx    = r_shift[0];
                end else begin
                    w_baud_nx = r_baud - 32'd1;
                end
            end
            S_DATA: begin
                if (w_baud_zero) begin
                    w_baud_nx = BaudReload;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud - 32'd1;
                end
            end
            S_STOP: begin
                if (w_baud_zero) begin
                    w_state_nx = S_IDLE;
                    w_tx_nx    = 1'b1;
                end else begin
                    w_baud_nx = r_baud - 32'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_tx    <= w_tx_nx;
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
            // Overflow set and status-write clear target different offsets,
            // so they never collide in one cycle.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; the control path above decides when
    // its contents are meaningful.
    always_ff @(posedge iwClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iwWriteData[7:0];
        end
        r_shift <= w_shift_nx;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk;
    logic        rst;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb5;
    logic [3:0]  wstrb1;
    logic [31:0] raddr;
    logic [31:0] rdata5, rdata1;
    logic        hit5, hit1, tx5, tx1, busy5, busy1;

    int n_cmp;
    int n_bad;
    bit m_ovf [2];

    int          b_n;
    logic [31:0] b_addr [16];
    logic [31:0] b_data [16];
    logic [3:0]  b_strb [16];

    mmio_uart_tx #(.pBaseAddr(BASE), .pClkPerBit(5), .pFifoAw(3)) u_dut5 (
        .iwClk(clk), .iwRst(rst), .iwWriteAddr(waddr), .iwWriteData(wdata),
        .iwWstrb(wstrb5), .iwReadAddr(raddr), .owReadData(rdata5),
        .owReadHit(hit5), .owTx(tx5), .owBusy(busy5)
    );

    mmio_uart_tx #(.pBaseAddr(BASE), .pClkPerBit(1), .pFifoAw(3)) u_dut1 (
        .iwClk(clk), .iwRst(rst), .iwWriteAddr(waddr), .iwWriteData(wdata),
        .iwWstrb(wstrb1), .iwReadAddr(raddr), .owReadData(rdata1),
        .owReadHit(hit1), .owTx(tx1), .owBusy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int which);
        return (which != 0) ? tx1 : tx5;
    endfunction
    function automatic logic get_busy(input int which);
        return (which != 0) ? busy1 : busy5;
    endfunction
    function automatic logic [31:0] get_rd(input int which);
        return (which != 0) ? rdata1 : rdata5;
    endfunction

    // Reference STATUS word built from the register-map description.
    function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit busy);
        logic [7:0] c;
        c = 8'(cnt);
        return {16'b0, c, 4'b0, ovf, busy, (cnt == 0), (cnt == 8)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int which, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        waddr = a;
        wdata = d;
        if (which != 0) wstrb1 = s; else wstrb5 = s;
        tick();
        wstrb1 = 4'b0;
        wstrb5 = 4'b0;
    endtask

    // Drives b_n consecutive writes into one DUT and checks the line
    // cycle-by-cycle against an ideal 8N1 waveform: each accepted byte is
    // 10*P cycles (start, 8 data LSB first, stop) and consecutive frames are
    // separated by exactly one idle cycle. The FIFO model applies the
    // push/drop/pop rules with the registered count.
    task automatic run_burst(input int which, input string name);
        int   p, cnt, first_edge, idx, nacc;
        bit   popped, acc, pop, word0;
        logic exp_wave[$];
        logic [7:0] bt;
        logic [31:0] exp_st;
        p = (which != 0) ? 1 : 5;
        cnt = 0; first_edge = -1; popped = 0; idx = 0; nacc = 0;
        exp_wave.delete();
        raddr = BASE + 32'd4;
        for (int i = 0; i < b_n; i++) begin
            word0 = (b_addr[i][31:3] == BASE[31:3]) && !b_addr[i][2] && b_strb[i][0];
            pop   = (first_edge >= 0) && !popped;
            acc   = word0 && (cnt < 8);
            if (word0 && cnt >= 8) m_ovf[which] = 1'b1;
            wr(which, b_addr[i], b_data[i], b_strb[i]);
            if (pop) popped = 1'b1;
            cnt = cnt + int'(acc) - int'(pop);
            if (acc) begin
                bt = b_data[i][7:0];
                if (nacc > 0) exp_wave.push_back(1'b1);
                for (int k = 0; k < 10; k++)
                    for (int c = 0; c < p; c++)
                        exp_wave.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bt[k-1]);
                nacc++;
                if (first_edge < 0) first_edge = i;
            end
            n_cmp++;
            if (first_edge >= 0 && i > first_edge) begin
                if (get_tx(which) !== exp_wave[idx]) begin
                    n_bad++;
                    $display("FAIL %s tx@%0d: got %b want %b", name, idx, get_tx(which), exp_wave[idx]);
                end
                idx++;
            end else if (get_tx(which) !== 1'b1) begin
                n_bad++;
                $display("FAIL %s tx idle before frame: got %b want 1", name, get_tx(which));
            end
        end
        exp_st = stat(cnt, m_ovf[which], nacc > 0);
        n_cmp++;
        if (get_rd(which) !== exp_st) begin
            n_bad++;
            $display("FAIL %s status after writes: got %h want %h", name, get_rd(which), exp_st);
        end
        while (idx < exp_wave.size()) begin
            tick();
            n_cmp++;
            if (get_tx(which) !== exp_wave[idx]) begin
                n_bad++;
                $display("FAIL %s tx@%0d: got %b want %b", name, idx, get_tx(which), exp_wave[idx]);
            end
            idx++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (get_tx(which) !== 1'b1) begin
                n_bad++;
                $display("FAIL %s tx idle after: got %b want 1", name, get_tx(which));
            end
        end
        n_cmp++;
        if (get_busy(which) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy after drain: got %b want 0", name, get_busy(which));
        end
        exp_st = stat(0, m_ovf[which], 1'b0);
        n_cmp++;
        if (get_rd(which) !== exp_st) begin
            n_bad++;
            $display("FAIL %s status idle: got %h want %h", name, get_rd(which), exp_st);
        end
    endtask

    task automatic test_reset;
        logic [7:0] bt;
        rst = 1'b0; waddr = '0; wdata = '0; wstrb5 = '0; wstrb1 = '0;
        raddr = BASE + 32'd4;
        #1 rst = 1'b1;
        #2;
        n_cmp += 4;
        if (tx5 !== 1'b1 || tx1 !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx: got %b/%b want 1/1", tx5, tx1);
        end
        if (busy5 !== 1'b0 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy5, busy1);
        end
        if (rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL reset_status5: got %h want 00000002", rdata5);
        end
        if (rdata1 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL reset_status1: got %h want 00000002", rdata1);
        end
        tick(); tick();
        #2 rst = 1'b0;
        m_ovf[0] = 0; m_ovf[1] = 0;
        tick();
        // Mid-run asynchronous reset during a start bit with bytes queued.
        bt = 8'($urandom);
        wr(0, BASE, {24'h0, bt}, 4'b0001);
        wr(0, BASE, $urandom, 4'b0001);
        wr(0, BASE, $urandom, 4'b0001);
        tick();
        n_cmp++;
        if (tx5 !== 1'b0) begin
            n_bad++; $display("FAIL reset_pre_start: got %b want 0", tx5);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (tx5 !== 1'b1) begin
            n_bad++; $display("FAIL reset_async_tx: got %b want 1", tx5);
        end
        if (busy5 !== 1'b0) begin
            n_bad++; $display("FAIL reset_async_busy: got %b want 0", busy5);
        end
        if (rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL reset_async_status: got %h want 00000002", rdata5);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_byte;
        b_n = 1;
        b_addr[0] = BASE; b_data[0] = 32'h0000_00A5; b_strb[0] = 4'b0001;
        run_burst(0, "single_a5");
        b_addr[0] = BASE + 32'($urandom_range(0, 3));
        b_data[0] = $urandom; b_strb[0] = 4'b0001 | 4'($urandom_range(0, 15));
        run_burst(0, "single_rand");
    endtask

    task automatic test_strobe_gating;
        b_n = 2;
        b_addr[0] = BASE; b_data[0] = 32'h0000_0055; b_strb[0] = 4'b0010;
        b_addr[1] = BASE; b_data[1] = $urandom;      b_strb[1] = 4'b1110;
        run_burst(0, "strobe_gate");
    endtask

    task automatic test_overflow;
        logic [7:0] s;
        s = 8'($urandom_range(0, 200));
        b_n = 10;
        for (int i = 0; i < 10; i++) begin
            b_addr[i] = BASE; b_data[i] = {24'h0, 8'(s + 8'(i))}; b_strb[i] = 4'b0001;
        end
        run_burst(0, "overflow");
    endtask

    task automatic test_overflow_clear_and_decode;
        raddr = BASE + 32'd4;
        #1;
        n_cmp++;
        if (rdata5 !== stat(0, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL ovf_held: got %h want %h", rdata5, stat(0, 1'b1, 1'b0));
        end
        wr(0, BASE + 32'd4, $urandom, 4'b1111);
        m_ovf[0] = 0;
        n_cmp += 2;
        if (rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL ovf_clear: got %h want 00000002", rdata5);
        end
        if (busy5 !== 1'b0) begin
            n_bad++; $display("FAIL status_wr_no_push: busy got %b want 0", busy5);
        end
        raddr = BASE + 32'd8; #1;
        n_cmp++;
        if (hit5 !== 1'b0 || rdata5 !== 32'b0) begin
            n_bad++; $display("FAIL dec_plus8: hit %b data %h want 0 0", hit5, rdata5);
        end
        raddr = BASE - 32'd4; #1;
        n_cmp++;
        if (hit5 !== 1'b0 || hit1 !== 1'b0) begin
            n_bad++; $display("FAIL dec_minus4: hit %b/%b want 0/0", hit5, hit1);
        end
        raddr = BASE; #1;
        n_cmp++;
        if (hit5 !== 1'b1 || rdata5 !== 32'b0) begin
            n_bad++; $display("FAIL dec_plus0: hit %b data %h want 1 0", hit5, rdata5);
        end
        raddr = BASE + 32'd7; #1;
        n_cmp++;
        if (hit5 !== 1'b1 || rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL dec_plus7: hit %b data %h want 1 00000002", hit5, rdata5);
        end
        raddr = BASE + 32'd4;
    endtask

    task automatic test_back_to_back;
        b_n = 2;
        b_addr[0] = BASE; b_data[0] = 32'h0000_000F; b_strb[0] = 4'b0001;
        b_addr[1] = BASE; b_data[1] = 32'h0000_00F0; b_strb[1] = 4'b0001;
        run_burst(1, "b2b_0f_f0");
        b_n = 4;
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = BASE; b_data[i] = $urandom; b_strb[i] = 4'b0001;
        end
        run_burst(1, "b2b_rand");
    endtask

    task automatic test_random_burst;
        int r;
        for (int rep = 0; rep < 4; rep++) begin
            b_n = (rep[0]) ? 8 : 10;
            for (int i = 0; i < b_n; i++) begin
                r = $urandom_range(0, 5);
                b_addr[i] = (r == 4) ? BASE + 32'd8 : (r == 5) ? BASE - 32'd4 : BASE + 32'(r);
                b_data[i] = $urandom;
                b_strb[i] = 4'($urandom_range(0, 15));
            end
            run_burst(rep[0] ? 1 : 0, rep[0] ? "rand_p1" : "rand_p5");
        end
    endtask

    task automatic test_reset_mid_data;
        logic [7:0] bt;
        bt = 8'($urandom);
        wr(0, BASE, {24'h0, bt}, 4'b0001);
        wr(0, BASE, $urandom, 4'b0001);
        // Now one cycle into the start bit; bit 3 spans cycles 20..24.
        for (int i = 0; i < 22; i++) tick();
        n_cmp++;
        if (tx5 !== bt[3]) begin
            n_bad++; $display("FAIL mid_data_bit3: got %b want %b", tx5, bt[3]);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (tx5 !== 1'b1) begin
            n_bad++; $display("FAIL mid_data_rst_tx: got %b want 1", tx5);
        end
        if (rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL mid_data_rst_status: got %h want 00000002", rdata5);
        end
        #2 rst = 1'b0;
        m_ovf[0] = 0; m_ovf[1] = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_cmp++;
            if (tx5 !== 1'b1) begin
                n_bad++; $display("FAIL mid_data_post_idle@%0d: got %b want 1", i, tx5);
            end
        end
        n_cmp++;
        if (rdata5 !== 32'h0000_0002) begin
            n_bad++; $display("FAIL mid_data_post_status: got %h want 00000002", rdata5);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_byte();
        test_strobe_gating();
        test_overflow();
        test_overflow_clear_and_decode();
        test_back_to_back();
        test_random_burst();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-write path, in parallel with bram_memory.
- Snoops the core write bus (address, data, byte strobes) and captures writes that fall in its address window into a small TX FIFO.
- Serializes queued bytes as 8N1 frames on a single output line.
- Exposes a combinational status word that the top-level read mux selects when the read address hits the window.

Parameters:
- pBaseAddr, 32'h0001_0000, word-aligned base of the 8-byte register window.
- pClkPerBit, 32'd5, iwClk cycles per UART bit, minimum 1.
- pFifoAw, 3, FIFO address width; depth = 2**pFifoAw = 8 entries.

Ports:
- iwClk  input  1  system clock (the divided core clock).
- iwRst  input  1  asynchronous, active-high reset.
- iwWriteAddr  input  32  core write address.
- iwWriteData  input  32  core write data.
- iwWstrb  input  4  byte strobes; a write occurs in any cycle where this is nonzero.
- iwReadAddr  input  32  core read address.
- owReadData  output  32  status word, combinational from iwReadAddr.
- owReadHit  output  1  high when iwReadAddr is in the window; the top mux selects owReadData over memory.
- owTx  output  1  serial line, idle high.
- owBusy  output  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Reset is applied asynchronously.
  - owTx=1, owBusy=0, FIFO empty (count=0), overflow flag=0, FSM=IDLE, bit counter=0, baud counter=0.
  - Reset mid-frame forces owTx=1 immediately and discards the frame and all queued bytes.
- Register map (word offsets; address bits [1:0] ignored for decode):
  - +0 TXDATA: write only. A push occurs when the address hits, iwWstrb[0]=1 and the FIFO is not full. The pushed byte is iwWriteData[7:0]. A write to +0 with iwWstrb[0]=0 has no effect.
  - +4 STATUS: read value is {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}, where count is zero-extended.
  - +4 STATUS write: any write with nonzero strobe clears overflow.
- Read path:
  - owReadHit = (iwReadAddr[31:3] == pBaseAddr[31:3]).
  - owReadData = STATUS for offset +4, 32'b0 for offset +0.
  - No clock latency.
- FIFO:
  - Synchronous circular buffer; pointers wrap modulo depth; separate count register of width pFifoAw+1.
  - "Full" uses the registered count. A push while full is dropped and sets overflow, even if a pop happens the same cycle.
  - Push and pop in the same cycle with the FIFO not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: owTx=1. If the FIFO is not empty, pop the head into the shift register, load the baud counter, go to START. owTx=0 is driven from the next cycle.
  - START: owTx=0 for pClkPerBit cycles, then DATA with bit index 0.
  - DATA: owTx=shift[0], held pClkPerBit cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: owTx=1 for pClkPerBit cycles, then IDLE.
  - IDLE may pop the next byte on its first cycle, so back-to-back frames have exactly 1 extra idle cycle between the end of STOP and the next START.
- Baud counter: counts down from pClkPerBit-1 to 0. At 0 it reloads and the bit advances. With pClkPerBit=1, every cycle is a bit.
- Latency:
  - Write captured at clock edge E.
  - FIFO non-empty after E.
  - IDLE pops at E+1.
  - owTx falls after E+1.
  - Frame duration: 10*pClkPerBit cycles.
- owBusy = (state != IDLE) || (count != 0), registered-state based.
- owTx is a register output; it never glitches.

Test Plan:
- Reset with pClkPerBit=5: assert iwRst mid-run → owTx=1, owBusy=0 and STATUS read = 32'h0000_0002 immediately, without waiting for a clock edge.
- Single byte: write 32'h0000_00A5 with strobe 4'b0001 to base+0 → owTx low 1 edge later, then bits 1,0,1,0,0,1,0,1 at 5 cycles each, stop high; total 50 cycles; owBusy then falls.
- Strobe gating: write 32'h0000_0055 to base+0 with strobe 4'b0010 → no push, count stays 0, owTx stays 1.
- Fill and overflow:
  - Hold the serializer busy and issue 10 back-to-back writes 0x00..0x09 → the first byte goes to the shifter, the next 8 fill the FIFO, the 10th is dropped.
  - After those writes, STATUS reads full=1, overflow=1, count=8.
  - Line output is 0x00..0x08 in order; 0x09 never appears.
- Overflow clear and read decode:
  - Write to base+4 with strobe 4'b1111 → overflow=0.
  - Reads at base+8 and base-4 → owReadHit=0; read at base+0 → hit, data 0.
- Back-to-back frames with pClkPerBit=1: two writes 0x0F, 0xF0 → frame 2 start bit begins exactly 1 cycle after frame 1 stop ends.
- Reset mid-DATA: assert iwRst during bit 3 → owTx=1 immediately; after release the line stays idle and count=0.
